// File: rtl/mysystem_spi_pkg.sv
// Shared constants for the SPI responder: register map, flag bit positions
// and the SPI frame width.
package mysystem_spi_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_TXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_CONTROL = 2'd3;

  localparam int ST_RRDY = 0;
  localparam int ST_TRDY = 1;
  localparam int ST_ROE  = 2;
  localparam int ST_BUSY = 3;

  localparam int CTL_IRRDY = 0;
  localparam int CTL_IROE  = 1;

endpackage

// File: rtl/mysystem_spi_sync.sv
// Two-flop synchroniser for an asynchronous SPI pin, with an extra flop
// to detect edges of the synchronised level. Reset value 0 means a pin
// already low at reset release never produces a falling-edge pulse.
module mysystem_spi_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchroniser chain plus previous-level flop for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      meta_r <= pin;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign level = sync_r;
  assign rise  = sync_r & ~prev_r;
  assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/mysystem_spi_responder.sv
// SPI mode-0 responder with a 4-word Avalon-MM register interface.
// SPI pins are oversampled by clk; MOSI bytes land in RXDATA, MISO bytes
// come from the TXDATA buffer.
module mysystem_spi_responder
  import mysystem_spi_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  input  logic        spi_csn,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe
);

  localparam int CNT_W = $clog2(DATA_W);

  logic csn_level_s, csn_rise_s, csn_fall_s;
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic mosi_level_s, mosi_rise_s, mosi_fall_s;
  logic unused_s;

  logic              busy_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic              reload_pend_r;
  logic              miso_r;
  logic [DATA_W-1:0] rx_data_r;
  logic [DATA_W-1:0] tx_buf_r;
  logic              rrdy_r;
  logic              trdy_r;
  logic              roe_r;
  logic [1:0]        ctrl_r;

  logic              rd_rx_s;
  logic              wr_tx_s;
  logic              wr_status_s;
  logic              wr_ctrl_s;
  logic              bit_rise_s;
  logic              bit_fall_s;
  logic              byte_done_s;
  logic              tx_load_s;
  logic [DATA_W-1:0] tx_load_val_s;
  logic [DATA_W-1:0] rx_byte_s;
  logic [3:0]        status_s;

  mysystem_spi_sync u_sync_csn (
    .clk(clk), .reset_n(reset_n), .pin(spi_csn),
    .level(csn_level_s), .rise(csn_rise_s), .fall(csn_fall_s)
  );

  mysystem_spi_sync u_sync_sclk (
    .clk(clk), .reset_n(reset_n), .pin(spi_sclk),
    .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s)
  );

  mysystem_spi_sync u_sync_mosi (
    .clk(clk), .reset_n(reset_n), .pin(spi_mosi),
    .level(mosi_level_s), .rise(mosi_rise_s), .fall(mosi_fall_s)
  );

  // Only edges of csn/sclk and the level of mosi matter here
  assign unused_s = ^{csn_level_s, sclk_level_s, mosi_rise_s, mosi_fall_s,
                      writedata[31:DATA_W]};

  assign rd_rx_s     = chipselect & ~read_n  & (address == REG_RXDATA);
  assign wr_tx_s     = chipselect & ~write_n & (address == REG_TXDATA);
  assign wr_status_s = chipselect & ~write_n & (address == REG_STATUS);
  assign wr_ctrl_s   = chipselect & ~write_n & (address == REG_CONTROL);

  // Frame end takes priority so a stray sclk edge at deselect is ignored
  assign bit_rise_s  = sclk_rise_s & busy_r & ~csn_rise_s;
  assign bit_fall_s  = sclk_fall_s & busy_r & ~csn_rise_s;
  assign byte_done_s = bit_rise_s & (bit_cnt_r == CNT_W'(DATA_W - 1));
  assign rx_byte_s   = {rx_shift_r[DATA_W-2:0], mosi_level_s};

  // A fresh buffer is consumed once; otherwise the responder sends zeros
  assign tx_load_s     = (csn_fall_s & ~csn_rise_s) | byte_done_s;
  assign tx_load_val_s = trdy_r ? {DATA_W{1'b0}} : tx_buf_r;

  // Frame tracking, bit counter and both shift registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r        <= 1'b0;
      bit_cnt_r     <= {CNT_W{1'b0}};
      rx_shift_r    <= {DATA_W{1'b0}};
      tx_shift_r    <= {DATA_W{1'b0}};
      reload_pend_r <= 1'b0;
      miso_r        <= 1'b0;
    end else if (csn_rise_s) begin
      busy_r        <= 1'b0;
      bit_cnt_r     <= {CNT_W{1'b0}};
      reload_pend_r <= 1'b0;
      miso_r        <= 1'b0;
    end else if (csn_fall_s) begin
      busy_r        <= 1'b1;
      bit_cnt_r     <= {CNT_W{1'b0}};
      tx_shift_r    <= tx_load_val_s;
      reload_pend_r <= 1'b0;
      miso_r        <= tx_load_val_s[DATA_W-1];
    end else if (bit_rise_s) begin
      rx_shift_r <= rx_byte_s;
      if (byte_done_s) begin
        bit_cnt_r     <= {CNT_W{1'b0}};
        // Reloaded MSB is presented on the following falling edge
        tx_shift_r    <= tx_load_val_s;
        reload_pend_r <= 1'b1;
      end else begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end
    end else if (bit_fall_s) begin
      if (reload_pend_r) begin
        reload_pend_r <= 1'b0;
        miso_r        <= tx_shift_r[DATA_W-1];
      end else begin
        tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
        miso_r     <= tx_shift_r[DATA_W-2];
      end
    end else begin
      busy_r <= busy_r;
    end
  end

  // Received byte register and receive-ready flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_data_r <= {DATA_W{1'b0}};
      rrdy_r    <= 1'b0;
    end else if (byte_done_s) begin
      // A read in the same cycle frees the register for the new byte
      if (!rrdy_r || rd_rx_s) begin
        rx_data_r <= rx_byte_s;
        rrdy_r    <= 1'b1;
      end else begin
        rrdy_r <= rrdy_r;
      end
    end else if (rd_rx_s) begin
      rrdy_r <= 1'b0;
    end else begin
      rrdy_r <= rrdy_r;
    end
  end

  // Overrun flag: set wins over a simultaneous write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      roe_r <= 1'b0;
    end else if (byte_done_s && rrdy_r && !rd_rx_s) begin
      roe_r <= 1'b1;
    end else if (wr_status_s && writedata[ST_ROE]) begin
      roe_r <= 1'b0;
    end else begin
      roe_r <= roe_r;
    end
  end

  // TX buffer and transmit-ready flag; a write lands after a same-cycle load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_buf_r <= {DATA_W{1'b0}};
      trdy_r   <= 1'b1;
    end else if (wr_tx_s) begin
      tx_buf_r <= writedata[DATA_W-1:0];
      trdy_r   <= 1'b0;
    end else if (tx_load_s) begin
      trdy_r <= 1'b1;
    end else begin
      trdy_r <= trdy_r;
    end
  end

  // Interrupt enable register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_r <= 2'b00;
    end else if (wr_ctrl_s) begin
      ctrl_r <= writedata[1:0];
    end else begin
      ctrl_r <= ctrl_r;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    status_s          = 4'd0;
    status_s[ST_RRDY] = rrdy_r;
    status_s[ST_TRDY] = trdy_r;
    status_s[ST_ROE]  = roe_r;
    status_s[ST_BUSY] = busy_r;
    readdata          = 32'd0;
    case (address)
      REG_RXDATA:  readdata = {{(32-DATA_W){1'b0}}, rx_data_r};
      REG_TXDATA:  readdata = 32'd0;
      REG_STATUS:  readdata = {28'd0, status_s};
      REG_CONTROL: readdata = {30'd0, ctrl_r};
      default:     readdata = 32'd0;
    endcase
  end

  assign irq         = (rrdy_r & ctrl_r[CTL_IRRDY]) | (roe_r & ctrl_r[CTL_IROE]);
  assign spi_miso    = miso_r;
  assign spi_miso_oe = busy_r;

endmodule

// File: tb/tb_mysystem_spi_responder.sv
// Randomised scoreboard bench for mysystem_spi_responder. A behavioural
// model of the register/flag rules predicts every register read and every
// MISO bit; monitors compare whenever the DUT presents data.
module tb_mysystem_spi_responder;
  import mysystem_spi_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_miso_oe;

  mysystem_spi_responder dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata),
    .readdata(readdata), .irq(irq), .spi_csn(spi_csn), .spi_sclk(spi_sclk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic [31:0] exp;
  } rd_item_t;

  rd_item_t rd_q[$];
  logic     miso_q[$];
  int       errors = 0;
  int       checks = 0;

  // Behavioural model state
  logic [7:0] m_rx, m_txbuf, tx_cur;
  logic       m_rrdy, m_trdy, m_roe, m_busy;
  logic [1:0] m_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_rx = 8'h00; m_txbuf = 8'h00; m_rrdy = 1'b0; m_trdy = 1'b1;
    m_roe = 1'b0; m_busy = 1'b0; m_ctrl = 2'b00; tx_cur = 8'h00;
  endfunction

  function automatic logic [7:0] model_load();
    logic [7:0] v;
    v = m_trdy ? 8'h00 : m_txbuf;
    m_trdy = 1'b1;
    return v;
  endfunction

  function automatic void model_complete(input logic [7:0] d);
    if (!m_rrdy) begin
      m_rx = d;
      m_rrdy = 1'b1;
    end else begin
      m_roe = 1'b1;
    end
  endfunction

  function automatic logic [31:0] exp_reg(input logic [1:0] a);
    case (a)
      2'd0: return {24'd0, m_rx};
      2'd2: return {28'd0, m_busy, m_roe, m_trdy, m_rrdy};
      2'd3: return {30'd0, m_ctrl};
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic exp_irq();
    return (m_rrdy & m_ctrl[0]) | (m_roe & m_ctrl[1]);
  endfunction

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    clk_wait(1);
    chipselect = 1'b0; write_n = 1'b1;
    case (a)
      2'd1: begin m_txbuf = d[7:0]; m_trdy = 1'b0; end
      2'd2: if (d[2]) m_roe = 1'b0;
      2'd3: m_ctrl = d[1:0];
      default: ;
    endcase
  endtask

  task automatic av_read(input logic [1:0] a);
    rd_item_t it;
    it.addr = a;
    it.exp  = exp_reg(a);
    rd_q.push_back(it);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    clk_wait(1);
    chipselect = 1'b0; read_n = 1'b1;
    if (a == 2'd0) m_rrdy = 1'b0;
  endtask

  task automatic frame_begin(input bit rd_status);
    spi_csn = 1'b0;
    tx_cur = model_load();
    clk_wait(4);
    m_busy = 1'b1;
    check("oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
    if (rd_status) av_read(REG_STATUS);
  endtask

  task automatic frame_end();
    clk_wait(4);
    spi_csn = 1'b1;
    clk_wait(6);
    m_busy = 1'b0;
    check("oe_after_frame", {31'd0, spi_miso_oe}, 32'd0);
  endtask

  // Clock nbits of one byte; optionally read RXDATA in the byte-complete cycle
  task automatic spi_byte(input logic [7:0] data, input int nbits, input bit rd_end, input bit live);
    for (int i = 0; i < nbits; i++) begin
      miso_q.push_back(live ? tx_cur[7-i] : 1'b0);
      spi_mosi = data[7-i];
      clk_wait(4);
      spi_sclk = 1'b1;
      if (rd_end && i == 7) begin
        clk_wait(2);
        av_read(REG_RXDATA);
        clk_wait(1);
      end else begin
        clk_wait(4);
      end
      spi_sclk = 1'b0;
    end
    if (live && nbits == 8) begin
      model_complete(data);
      tx_cur = model_load();
    end
  endtask

  // Register-read monitor
  always @(negedge clk) begin
    if (chipselect && !read_n) begin
      if (rd_q.size() == 0) begin
        check("read_unexpected", readdata, 32'hFFFF_FFFF);
      end else begin
        rd_item_t it;
        it = rd_q.pop_front();
        check($sformatf("read_reg%0d", it.addr), readdata, it.exp);
      end
    end
  end

  // MISO monitor: master samples on sclk rising edges
  always @(posedge spi_sclk) begin
    if (!spi_csn) begin
      if (miso_q.size() == 0) begin
        check("miso_unexpected", 32'd0, 32'd1);
      end else begin
        logic e;
        e = miso_q.pop_front();
        check("miso_bit", {31'd0, spi_miso}, {31'd0, e});
      end
    end
  end

  initial begin
    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1;
    write_n = 1'b1; writedata = 32'd0; spi_csn = 1'b1; spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    model_reset();
    clk_wait(3);
    reset_n = 1'b1;
    clk_wait(3);

    // Reset state
    check("irq_reset", {31'd0, irq}, 32'd0);
    check("oe_reset", {31'd0, spi_miso_oe}, 32'd0);
    check("miso_reset", {31'd0, spi_miso}, 32'd0);
    av_read(REG_STATUS);
    av_read(REG_RXDATA);
    av_read(REG_CONTROL);

    // Receive 0xA5 with RRDY interrupt enabled
    av_write(REG_CONTROL, 32'h1);
    frame_begin(1'b0);
    spi_byte(8'hA5, 8, 1'b0, 1'b1);
    frame_end();
    check("irq_rrdy", {31'd0, irq}, {31'd0, exp_irq()});
    av_read(REG_STATUS);
    av_read(REG_RXDATA);
    check("irq_cleared", {31'd0, irq}, {31'd0, exp_irq()});

    // Transmit 0x3C; TRDY reads back 1 once the frame has started
    av_write(REG_TXDATA, 32'h3C);
    av_read(REG_STATUS);
    frame_begin(1'b1);
    spi_byte(8'h00, 8, 1'b0, 1'b1);
    frame_end();
    av_read(REG_RXDATA);

    // Overrun: two bytes without a read
    av_write(REG_CONTROL, 32'h2);
    frame_begin(1'b0);
    spi_byte(8'h11, 8, 1'b0, 1'b1);
    frame_end();
    frame_begin(1'b0);
    spi_byte(8'h22, 8, 1'b0, 1'b1);
    frame_end();
    check("irq_roe", {31'd0, irq}, {31'd0, exp_irq()});
    av_read(REG_RXDATA);
    av_read(REG_STATUS);
    av_write(REG_STATUS, 32'h4);
    av_read(REG_STATUS);
    check("irq_roe_cleared", {31'd0, irq}, {31'd0, exp_irq()});

    // Aborted frame after 5 bits, then a full frame
    frame_begin(1'b0);
    spi_byte(8'hF0, 5, 1'b0, 1'b1);
    frame_end();
    av_read(REG_STATUS);
    frame_begin(1'b0);
    spi_byte(8'h81, 8, 1'b0, 1'b1);
    frame_end();
    av_read(REG_RXDATA);

    // Read RXDATA in the exact cycle the second byte completes
    frame_begin(1'b0);
    spi_byte(8'h5A, 8, 1'b0, 1'b1);
    spi_byte(8'hC3, 8, 1'b1, 1'b1);
    frame_end();
    av_read(REG_STATUS);
    av_read(REG_RXDATA);
    av_read(REG_STATUS);

    // Randomised traffic
    for (int it = 0; it < 24; it++) begin
      int nb;
      if ($urandom_range(1, 0) == 1) av_write(REG_CONTROL, 32'($urandom_range(3, 0)));
      if ($urandom_range(1, 0) == 1) av_write(REG_TXDATA, $urandom);
      nb = $urandom_range(2, 1);
      frame_begin($urandom_range(1, 0) == 1);
      for (int b = 0; b < nb; b++) begin
        spi_byte(8'($urandom), 8, ($urandom_range(3, 0) == 0), 1'b1);
      end
      frame_end();
      check("irq_rand", {31'd0, irq}, {31'd0, exp_irq()});
      if ($urandom_range(1, 0) == 1) av_read(REG_RXDATA);
      av_read(REG_STATUS);
      if ($urandom_range(1, 0) == 1) av_write(REG_STATUS, 32'h4);
    end

    // Reset mid-frame, released while csn is still low
    av_write(REG_CONTROL, 32'h3);
    av_write(REG_TXDATA, 32'hE7);
    frame_begin(1'b0);
    spi_byte(8'h96, 3, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check("oe_async_reset", {31'd0, spi_miso_oe}, 32'd0);
    check("miso_async_reset", {31'd0, spi_miso}, 32'd0);
    check("irq_async_reset", {31'd0, irq}, 32'd0);
    model_reset();
    clk_wait(2);
    reset_n = 1'b1;
    clk_wait(2);
    spi_byte(8'hFF, 8, 1'b0, 1'b0);
    check("oe_no_frame", {31'd0, spi_miso_oe}, 32'd0);
    clk_wait(4);
    spi_csn = 1'b1;
    clk_wait(6);
    av_read(REG_STATUS);
    av_read(REG_RXDATA);

    clk_wait(2);
    check("read_queue_drained", 32'(rd_q.size()), 32'd0);
    check("miso_queue_drained", 32'(miso_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mysystem_spi_responder.md
# mysystem_spi_responder

SPI responder (slave) on the same bus segment as the SoC chip-select PIO, placed on the far side of the SPI link. It deserialises MOSI bytes framed by `spi_csn` and serialises MISO bytes supplied by the CPU. It exposes both through a 4-word Avalon-MM slave with status flags and an interrupt. The fixed format is mode 0 (CPOL=0, CPHA=0), 8-bit, MSB first; SPI pins are oversampled by `clk`.

## Interface
- `DATA_W`, 8: bits per SPI frame (fixed at 8 for this release).
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `address`  in  2: register word select.
- `chipselect`  in  1: Avalon slave select.
- `read_n`  in  1: active-low read strobe (one cycle per access).
- `write_n`  in  1: active-low write strobe.
- `writedata`  in  32: write data.
- `readdata`  out  32: read data, combinational from `address`, zero wait states.
- `irq`  out  1: level interrupt.
- `spi_csn`  in  1: frame select, active low; asynchronous to `clk`.
- `spi_sclk`  in  1: SPI clock; asynchronous; frequency must be at most f(clk)/8.
- `spi_mosi`  in  1: serial data in.
- `spi_miso`  out  1: serial data out.
- `spi_miso_oe`  out  1: MISO output enable, equal to frame active.

## Operation
- Registers:
  - 0 RXDATA (RO): [7:0] last received byte. A read strobe clears RRDY.
  - 1 TXDATA (WO): a write loads [7:0] into the TX buffer and clears TRDY.
  - 2 STATUS: [0] RRDY, [1] TRDY, [2] ROE, [3] BUSY (frame active). ROE is write-1-to-clear; other bits are RO.
  - 3 CONTROL (RW): [0] IRRDY, [1] IROE.
- `irq` = (RRDY & IRRDY) | (ROE & IROE).
- Unused `readdata` bits read 0.
- Frame start: on the synchronised `spi_csn` falling edge:
  - BUSY=1; bit counter=0.
  - TX shift register loads the TX buffer if TRDY=0, else 0x00. TRDY then becomes 1.
  - `spi_miso` = shift[7].
- Synchronised `sclk` rising edge while BUSY: shift in `spi_mosi` as the LSB; counter +1.
- Synchronised `sclk` falling edge while BUSY: TX shift left by 1; `spi_miso` = new shift[7].
- 8th rising edge (byte complete):
  - Counter wraps to 0.
  - If RRDY=0: RXDATA = assembled byte, RRDY=1.
  - If RRDY=1: ROE=1, RXDATA is kept, new byte dropped.
  - TX shift reloads from the TX buffer with the same rule as frame start; this takes effect on the next falling edge, which outputs the new MSB.
- Frame end (synchronised `spi_csn` rising edge): BUSY=0; a partial byte is discarded with no flag change; counter=0; `spi_miso_oe`=0.
- Simultaneous events:
  - RXDATA read strobe in the same cycle as byte complete: the new byte is stored, RRDY stays 1, no ROE.
  - TXDATA write in the same cycle as a TX load: the load uses the pre-write buffer state. The write then sets the buffer and TRDY=0.
  - ROE clear in the same cycle as a new overrun: ROE stays 1.

## Timing
- Reset values: RXDATA=0, TX buffer=0, RRDY=0, TRDY=1, ROE=0, CONTROL=0, `irq`=0, `spi_miso`=0, `spi_miso_oe`=0, counter=0, BUSY=0.
- Pin synchronisers are 2 flops plus an edge-detect flop. An SPI pin edge is acted on 3 `clk` cycles later.
- RRDY and `irq` assert 1 cycle after the internal byte-complete event.
- `spi_miso` changes 3 `clk` cycles after the `sclk` falling edge. This is within half an SCLK period given the f(clk)/8 limit.
- Register writes take effect on the next `clk`; reads are same-cycle.
- Reset assertion mid-frame forces reset values immediately; the frame is abandoned. After release, a frame is recognised only from a new `spi_csn` falling edge.

## Structure
- Shared package `mysystem_spi_pkg`: register offsets (RXDATA=0, TXDATA=1, STATUS=2, CONTROL=3), STATUS/CONTROL bit indices, `DATA_W`.
- Sub-module `mysystem_spi_sync`: 2-flop synchroniser plus rise/fall pulse outputs. Instantiated 3× (csn, sclk, mosi; mosi uses the level only).
- The top level holds the Avalon register file, bit counter, RX/TX shift registers and flag logic.

## Test plan
- Reset, then read STATUS -> 0x2 (TRDY=1); `irq`=0, `spi_miso_oe`=0.
- CONTROL=0x1; master sends 0xA5 in one frame -> RXDATA=0xA5, RRDY=1, `irq`=1. Read RXDATA -> RRDY=0, `irq`=0.
- TXDATA=0x3C before frame; master clocks 8 bits -> MISO sequence 0,0,1,1,1,1,0,0 sampled on rising edges. TRDY=1 after frame start.
- Two bytes 0x11, 0x22 with no CPU read -> RXDATA=0x11, ROE=1. Write STATUS=0x4 -> ROE=0.
- Frame aborted after 5 bits (csn high) -> RRDY stays 0. The next full frame with 0x81 -> RXDATA=0x81.
- Read RXDATA in the exact cycle a second byte completes -> RRDY remains 1, ROE=0, RXDATA holds the new byte.
